// File: rtl/spram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between requesters A and B.
// Define ARB_STATS_EN to add the saturating 16-bit grant counters cnt_a/cnt_b.
module spram_rr_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          ram_ce,
  output logic          ram_we,
  output logic [AW-1:0] ram_adr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]   cnt_a,
  output logic [15:0]   cnt_b
`endif
);

  logic last_gnt_q, last_gnt_d;   // 0 = A served last, 1 = B served last
  logic rd_pend_a_q, rd_pend_a_d;
  logic rd_pend_b_q, rd_pend_b_d;

  // Grant selection: contention goes to whoever was not served last; nothing is granted in reset
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!nrst) begin
      a_gnt = 1'b0;
      b_gnt = 1'b0;
    end else if (a_req && b_req) begin
      a_gnt = last_gnt_q;
      b_gnt = ~last_gnt_q;
    end else begin
      a_gnt = a_req;
      b_gnt = b_req;
    end
  end

  // RAM command mux
  always_comb begin
    ram_ce  = 1'b0;
    ram_we  = 1'b0;
    ram_adr = {AW{1'b0}};
    ram_din = {DW{1'b0}};
    if (a_gnt) begin
      ram_ce  = 1'b1;
      ram_we  = a_we;
      ram_adr = a_addr;
      ram_din = a_wdata;
    end else if (b_gnt) begin
      ram_ce  = 1'b1;
      ram_we  = b_we;
      ram_adr = b_addr;
      ram_din = b_wdata;
    end else begin
      ram_ce  = 1'b0;
      ram_we  = 1'b0;
      ram_adr = {AW{1'b0}};
      ram_din = {DW{1'b0}};
    end
  end

  // Next-state: priority pointer moves only on a grant; reads remember their owner for one cycle
  always_comb begin
    last_gnt_d = last_gnt_q;
    if (a_gnt) begin
      last_gnt_d = 1'b0;
    end else if (b_gnt) begin
      last_gnt_d = 1'b1;
    end else begin
      last_gnt_d = last_gnt_q;
    end
    rd_pend_a_d = a_gnt & ~a_we;
    rd_pend_b_d = b_gnt & ~b_we;
  end

  // Arbiter state registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      last_gnt_q  <= 1'b1;
      rd_pend_a_q <= 1'b0;
      rd_pend_b_q <= 1'b0;
    end else begin
      last_gnt_q  <= last_gnt_d;
      rd_pend_a_q <= rd_pend_a_d;
      rd_pend_b_q <= rd_pend_b_d;
    end
  end

  assign a_rvalid = rd_pend_a_q;
  assign b_rvalid = rd_pend_b_q;
  assign a_rdata  = rd_pend_a_q ? ram_dout : {DW{1'b0}};
  assign b_rdata  = rd_pend_b_q ? ram_dout : {DW{1'b0}};

`ifdef ARB_STATS_EN
  logic [15:0] cnt_a_q, cnt_a_d;
  logic [15:0] cnt_b_q, cnt_b_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic inc);
    if (inc && (v != 16'hFFFF)) begin
      sat_inc = v + 16'd1;
    end else begin
      sat_inc = v;
    end
  endfunction

  // Counter next-state
  always_comb begin
    cnt_a_d = sat_inc(cnt_a_q, a_gnt);
    cnt_b_d = sat_inc(cnt_b_q, b_gnt);
  end

  // Grant counter registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_a_q <= 16'h0000;
      cnt_b_q <= 16'h0000;
    end else begin
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  assign cnt_a = cnt_a_q;
  assign cnt_b = cnt_b_q;
`endif

endmodule
